// File: rtl/processor_pkg.sv
// Shared constants and types for the memory-mapped I/O responder.
package processor_pkg;

    // Processor data/address width
    localparam int RW = 24;

    // Base of the 16-word I/O window
    localparam logic [RW-1:0] IO_BASE = 24'hFF0000;

    // Register offsets inside the window
    localparam logic [3:0] IO_SW    = 4'd0;
    localparam logic [3:0] IO_SWCHG = 4'd1;
    localparam logic [3:0] IO_G1L   = 4'd2;
    localparam logic [3:0] IO_G1H   = 4'd3;
    localparam logic [3:0] IO_G2L   = 4'd4;
    localparam logic [3:0] IO_G2H   = 4'd5;
    localparam logic [3:0] IO_CYC   = 4'd6;

    // GPIO bank geometry: 24-bit low word plus 12-bit high word
    localparam int GPIO_W    = 36;
    localparam int GPIO_LO_W = 24;
    localparam int GPIO_HI_W = GPIO_W - GPIO_LO_W;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } io_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input bus, with a one-cycle
// pulse whenever the synchronized value differs from the previous one.
module sync_edge_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic             change_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    // Synchronizer chain plus one history stage for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o   = sync_q;
    assign change_o = |(sync_q ^ prev_q);

endmodule

// File: rtl/mem_io_responder.sv
// Memory-mapped I/O responder: answers loads/stores in a 16-word window,
// owning switches, two 36-bit GPIO banks and a free-running cycle counter,
// and stalls the pipeline until each access has committed.
module mem_io_responder
    import processor_pkg::*;
#(
    parameter int             N           = RW,
    parameter logic [N-1:0]   IO_BASE     = processor_pkg::IO_BASE,
    parameter int             WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic               we,
    input  logic [N-1:0]       address,
    input  logic [N-1:0]       writeData,
    output logic [N-1:0]       q,
    output logic               stall,
    input  logic [3:0]         switches,
    output logic [GPIO_W-1:0]  gpio1,
    output logic [GPIO_W-1:0]  gpio2
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    io_state_t            state_q, state_d;
    logic                 we_q, we_d;
    logic [3:0]           off_q, off_d;
    logic [N-1:0]         wdata_q, wdata_d;
    logic [3:0]           wait_q, wait_d;
    logic [N-1:0]         q_q, q_d;
    logic [GPIO_W-1:0]    gpio1_q, gpio1_d;
    logic [GPIO_W-1:0]    gpio2_q, gpio2_d;
    logic [N-1:0]         cyc_q, cyc_d;
    logic                 chg_q, chg_d;

    logic                 hit;
    logic                 commit;
    logic [N-1:0]         rdata;
    logic [3:0]           sw_sync;
    logic                 sw_change;

    // Only the upper address bits select the window; the low nibble is the register offset
    assign hit = req & (address[N-1:4] == IO_BASE[N-1:4]);

    sync_edge_detect #(
        .WIDTH (4)
    ) u_sw_sync (
        .clk      (clk),
        .rst_n    (rst),
        .async_i  (switches),
        .sync_o   (sw_sync),
        .change_o (sw_change)
    );

    // Sequencer next state: latch the request in IDLE, count wait states, commit, release
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        wait_d  = wait_q;
        stall   = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                stall = hit;
                if (hit) begin
                    we_d    = we;
                    off_d   = address[3:0];
                    wdata_d = writeData;
                    wait_d  = WAIT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Same instruction is still presented; its req must not retrigger
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read mux for the latched offset; unmapped offsets read as zero
    always_comb begin
        rdata = '0;
        case (off_q)
            IO_SW:    rdata[3:0]           = sw_sync;
            IO_SWCHG: rdata[0]             = chg_q;
            IO_G1L:   rdata[GPIO_LO_W-1:0] = gpio1_q[GPIO_LO_W-1:0];
            IO_G1H:   rdata[GPIO_HI_W-1:0] = gpio1_q[GPIO_W-1:GPIO_LO_W];
            IO_G2L:   rdata[GPIO_LO_W-1:0] = gpio2_q[GPIO_LO_W-1:0];
            IO_G2H:   rdata[GPIO_HI_W-1:0] = gpio2_q[GPIO_W-1:GPIO_LO_W];
            IO_CYC:   rdata                = cyc_q;
            default:  rdata                = '0;
        endcase
    end

    // Register file updates at commit, change latch and free-running counter
    always_comb begin
        gpio1_d = gpio1_q;
        gpio2_d = gpio2_q;
        q_d     = q_q;
        chg_d   = chg_q;
        cyc_d   = cyc_q + 1'b1;
        if (commit) begin
            if (we_q) begin
                case (off_q)
                    IO_G1L:  gpio1_d[GPIO_LO_W-1:0]      = wdata_q[GPIO_LO_W-1:0];
                    IO_G1H:  gpio1_d[GPIO_W-1:GPIO_LO_W] = wdata_q[GPIO_HI_W-1:0];
                    IO_G2L:  gpio2_d[GPIO_LO_W-1:0]      = wdata_q[GPIO_LO_W-1:0];
                    IO_G2H:  gpio2_d[GPIO_W-1:GPIO_LO_W] = wdata_q[GPIO_HI_W-1:0];
                    default: ;
                endcase
            end else begin
                q_d = rdata;
                if (off_q == IO_SWCHG) begin
                    chg_d = 1'b0;
                end
            end
        end
        // A fresh switch change must never be lost to a concurrent read-clear
        if (sw_change) begin
            chg_d = 1'b1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            q_q     <= '0;
            gpio1_q <= '0;
            gpio2_q <= '0;
            cyc_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
            q_q     <= q_d;
            gpio1_q <= gpio1_d;
            gpio2_q <= gpio2_d;
            cyc_q   <= cyc_d;
            chg_q   <= chg_d;
        end
    end

    assign q     = q_q;
    assign gpio1 = gpio1_q;
    assign gpio2 = gpio2_q;

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-mapped I/O responder on the far side of the memory stage's access interface. Answers processor loads and stores that fall in the I/O window.
- Owns the switch inputs, the two 36-bit GPIO output banks and a free-running cycle counter.
- Holds the pipeline through the hazard unit's stall input until each I/O access completes.
- Accesses outside the window are ignored and left to data memory.

Parameters:
- N, 24, data/address width (matches RW).
- IO_BASE, 24'hFF0000, base address of the I/O window; the window is IO_BASE..IO_BASE+15 (word offsets 0..15).
- WAIT_CYCLES, 1, extra wait states spent in ACCESS before commit (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- req  in  1  memory stage access valid (memWrite | memToReg)
- we  in  1  1 = store, 0 = load
- address  in  N  byte/word address from memory stage (address1)
- writeData  in  N  store data
- q  out  N  load data returned to memory stage
- stall  out  1  to hazard unit; holds IF..MEM while an I/O access is in progress
- switches  in  4  board switches, asynchronous
- gpio1  out  36  GPIO bank 1
- gpio2  out  36  GPIO bank 2

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-low.
- Reset values: state=IDLE, q=0, stall=0, gpio1=0, gpio2=0, sync flops=0, change latch=0, cycle counter=0, wait counter=0.
- Reset mid-operation: return to IDLE immediately; an uncommitted store is dropped.
- hit = req & (address[N-1:4] == IO_BASE[N-1:4]); off = address[3:0].
- Register map by off:
  - 0: switches, 2-flop synchronized, zero-extended, RO.
  - 1: change latch in bit0, RO, clear-on-read.
  - 2: gpio1[23:0], RW.
  - 3: gpio1[35:24] in bits 11:0, RW, upper bits read 0.
  - 4: gpio2[23:0], RW.
  - 5: gpio2[35:24], RW.
  - 6: cycle counter, RO, N bits, wraps 2^N-1 -> 0.
  - 7..15: read 0, writes ignored.
  - Stores to RO registers are ignored.
- FSM states IDLE, ACCESS, DONE:
  - IDLE: stall = hit, combinational in the same cycle. If hit: latch we/off/writeData, load wait counter = WAIT_CYCLES, go to ACCESS. Otherwise stay; q holds its last value.
  - ACCESS: stall=1. While wait counter > 0, decrement it. When it is 0, commit: a store updates the target register; a load registers read data into q and clears the change latch if off=1. Then go to DONE.
  - DONE: stall=0 and q valid; the pipeline advances at this edge. req is ignored this cycle (it is the same instruction). Go to IDLE.
- Latency with WAIT_CYCLES=W: stall high for W+2 cycles (IDLE hit cycle plus W+1 ACCESS cycles). q valid in DONE.
- Back-to-back I/O accesses: the second request is seen in the IDLE cycle after DONE; there is no gap beyond that.
- Change latch: set when the synchronized switches differ from the previous synchronized value. If a set and a clear-on-read happen in the same cycle, set wins.
- Cycle counter increments every clock, including during stalls.
- A non-hit req never asserts stall and never changes any register.

Decomposition:
- Shared package (processor_pkg): RW, IO_BASE, register offset constants (IO_SW, IO_SWCHG, IO_G1L, IO_G1H, IO_G2L, IO_G2H, IO_CYC), and a state typedef io_state_t {IDLE, ACCESS, DONE}.
- One sub-module: sync_edge_detect (2-flop synchronizer with change pulse output, parameter width 4).

Test Plan:
- Reset: rst low mid-ACCESS with a pending store 0x123456 to off 2 -> gpio1=0, stall=0, state IDLE; the store is never applied.
- Store then load, W=1: store 0xABCDEF to IO_BASE+2, then load IO_BASE+2 -> stall high 3 cycles each, gpio1[23:0]=0xABCDEF, q=0xABCDEF in DONE.
- High half: store 0xFFFFFF to IO_BASE+5 -> gpio2[35:24]=0xFFF, gpio2[23:0] unchanged; load IO_BASE+5 returns 0x000FFF.
- Switch change: switches 0000 -> 1010 -> load off 0 returns 0x00000A after sync; load off 1 returns 1, immediate reload returns 0; a switch toggle in the clearing cycle leaves the latch at 1.
- Non-hit: req=1 at address 0x000100 -> stall stays 0, q and GPIO unchanged.
- Counter wrap with W=0: preload counter to 0xFFFFFF via a bench force -> next cycle reads 0x000000; the stall window is exactly 2 cycles.
